// File: rtl/crc_pkg.sv
// Shared constants and types for the CRC AHB-Lite feeder: CRC IP register
// offsets, AHB encodings and the feeder FSM state type.
package crc_pkg;

   // CRC IP register map, relative to the IP base address
   localparam logic [31:0] CRC_DR_OFS   = 32'h0000_0000;
   localparam logic [31:0] CRC_CR_OFS   = 32'h0000_0008;
   // CR value that reloads INIT into the CRC chain (bit 0 = RESET)
   localparam logic [31:0] CRC_CR_RESET = 32'h0000_0001;

   // AHB-Lite encodings used by the feeder
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   // Feeder job sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CR_A = 3'd1,
      ST_WR_A = 3'd2,
      ST_RD_A = 3'd3,
      ST_RD_D = 3'd4,
      ST_FIN  = 3'd5
   } feed_state_e;

endpackage

// File: rtl/crc_ahb_feeder.sv
// AHB-Lite master that resets the CRC IP, streams N source words into its
// data register with pipelined single writes, then reads the result back.
//
// Source handshake (valid/ready): s_valid may rise at any time and, once
// high, must stay high with s_data stable until a cycle where s_ready is also
// high; that cycle transfers exactly one word. s_ready never depends on
// s_valid. The DR write address phase for a word is accepted on the bus in
// the same cycle the word transfers, so a held s_valid keeps the address
// phase stable across HREADY wait states.
module crc_ahb_feeder
   import crc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              start,
   input  logic [31:0]       crc_base,
   input  logic [CNT_W-1:0]  word_cnt,
   input  logic              s_valid,
   input  logic [31:0]       s_data,
   output logic              s_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       crc_value,
   output logic [31:0]       HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   output feed_state_e       dbg_state
);

   feed_state_e       state_q, state_d;
   logic [31:0]       base_q;
   logic [CNT_W-1:0]  rem_q;
   logic [31:0]       hwdata_q, wdata_nxt;
   logic              pending_q;
   logic              busy_q, done_q, err_q;
   logic [31:0]       crc_q;

   logic [1:0]        htrans_c;
   logic [31:0]       haddr_c;
   logic              hwrite_c;
   logic              s_rdy_c;
   logic              addr_accept;
   logic              word_take;
   logic              err_hit;
   logic              start_ok;

   // First cycle of a two-cycle ERROR response on the outstanding data phase
   assign err_hit  = pending_q & HRESP & ~HREADY;
   assign start_ok = (state_q == ST_IDLE) & start;

   // Next-state, address-phase drive and source handshake
   always_comb begin
      state_d     = state_q;
      htrans_c    = HTRANS_IDLE;
      haddr_c     = '0;
      hwrite_c    = 1'b0;
      s_rdy_c     = 1'b0;
      addr_accept = 1'b0;
      word_take   = 1'b0;
      wdata_nxt   = hwdata_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_CR_A;
         end
         ST_CR_A: begin
            htrans_c = HTRANS_NONSEQ;
            haddr_c  = base_q + CRC_CR_OFS;
            hwrite_c = 1'b1;
            if (HREADY) begin
               addr_accept = 1'b1;
               wdata_nxt   = CRC_CR_RESET;
               state_d     = (rem_q == '0) ? ST_RD_A : ST_WR_A;
            end
         end
         ST_WR_A: begin
            haddr_c  = base_q + CRC_DR_OFS;
            hwrite_c = 1'b1;
            s_rdy_c  = (rem_q != '0) & HREADY;
            // no word available: bus stays IDLE until the source catches up
            if (s_valid && (rem_q != '0)) htrans_c = HTRANS_NONSEQ;
            if (s_valid && s_rdy_c) begin
               addr_accept = 1'b1;
               word_take   = 1'b1;
               wdata_nxt   = s_data;
               if (rem_q == CNT_W'(1)) state_d = ST_RD_A;
            end
         end
         ST_RD_A: begin
            htrans_c = HTRANS_NONSEQ;
            haddr_c  = base_q + CRC_DR_OFS;
            if (HREADY) begin
               addr_accept = 1'b1;
               state_d     = ST_RD_D;
            end
         end
         ST_RD_D: begin
            haddr_c = base_q + CRC_DR_OFS;
            if (HREADY) state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // An error abandons the job; FIN drives IDLE in the second error cycle,
      // which cancels whatever address phase was being held.
      if (err_hit) state_d = ST_FIN;
   end

   // FSM state register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Job context, data-phase tracking and status registers
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         base_q    <= '0;
         rem_q     <= '0;
         hwdata_q  <= '0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         crc_q     <= '0;
      end else begin
         if (start_ok) begin
            base_q <= crc_base & ~32'h3;
            rem_q  <= word_cnt;
            err_q  <= 1'b0;
         end else if (word_take) begin
            rem_q <= rem_q - CNT_W'(1);
         end
         // write data follows its address phase by one accepted cycle
         if (addr_accept) hwdata_q <= wdata_nxt;
         if (err_hit)          pending_q <= 1'b0;
         else if (addr_accept) pending_q <= 1'b1;
         else if (HREADY)      pending_q <= 1'b0;
         if (err_hit) err_q <= 1'b1;
         if ((state_q == ST_RD_D) && HREADY && !HRESP) crc_q <= HRDATA;
         busy_q <= (state_d != ST_IDLE);
         done_q <= (state_d == ST_FIN);
      end
   end

   assign s_ready   = s_rdy_c;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign crc_value = crc_q;
   assign HADDR     = haddr_c;
   assign HTRANS    = htrans_c;
   assign HWRITE    = hwrite_c;
   assign HSIZE     = HSIZE_WORD;
   assign HWDATA    = hwdata_q;
   assign dbg_state = state_q;

endmodule
